// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the MIPS register file.
package mips_rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int MAX_DEPTH = 64;
  localparam int CNT_W = 7;

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_DEPTH-1:0] vec);
    logic [CNT_W-1:0] acc;
    acc = 7'd0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      acc = acc + {6'd0, vec[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by writeback.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_0,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_0,
  input  logic                         wr_en_1,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_1,
  input  logic                         issue_en,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_ready,
  output logic [ADDR_WIDTH:0]          pending_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0]    pending_q, pending_d;
  logic [DEPTH-1:0]    set_s, clr_s;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  // Next pending vector: a new producer outranks a retiring one in the same cycle.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    if (issue_en) begin
      set_s[issue_addr] = 1'b1;
    end else begin
      set_s = '0;
    end
    if (wr_en_0) begin
      clr_s[wr_addr_0] = 1'b1;
    end else begin
      clr_s[wr_addr_0] = clr_s[wr_addr_0];
    end
    if (wr_en_1) begin
      clr_s[wr_addr_1] = 1'b1;
    end else begin
      clr_s[wr_addr_1] = clr_s[wr_addr_1];
    end
    set_s[0] = 1'b0;
    clr_s[0] = 1'b0;
    pending_d = (pending_q & ~clr_s) | set_s;
    cnt_d = (ADDR_WIDTH+1)'(popcount(MAX_DEPTH'(pending_d)));
  end

  // Pending vector and its population count update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ready
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  hit_s;
    logic                  ready_s;

    assign addr_s = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // With bypass, a value arriving this cycle is as good as a stored one.
    always_comb begin
      hit_s = (wr_en_0 && (wr_addr_0 == addr_s)) || (wr_en_1 && (wr_addr_1 == addr_s));
      if (addr_s == ZERO_A) begin
        ready_s = 1'b1;
      end else if ((BYPASS != 0) && hit_s) begin
        ready_s = 1'b1;
      end else begin
        ready_s = ~pending_q[addr_s];
      end
    end

    assign rd_ready[k] = ready_s;
  end

endmodule

// File: rtl/mips_reg_file_mp.sv
// Multi-port MIPS register file: NUM_RD combinational reads, two write lanes (lane 1 wins),
// optional write-to-read bypass, and a RAW-hazard scoreboard.
module mips_reg_file_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WR_EN_0,
  input  logic [ADDR_WIDTH-1:0]        WR_ADDR_0,
  input  logic [DATA_WIDTH-1:0]        WR_DATA_0,
  input  logic                         WR_EN_1,
  input  logic [ADDR_WIDTH-1:0]        WR_ADDR_1,
  input  logic [DATA_WIDTH-1:0]        WR_DATA_1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA,
  output logic [NUM_RD-1:0]            RD_READY,
  input  logic                         ISSUE_EN,
  input  logic [ADDR_WIDTH-1:0]        ISSUE_ADDR,
  output logic [ADDR_WIDTH:0]          PENDING_CNT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // Lane 1 is checked first so it wins a same-address collision; entry 0 never changes.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      if (r == 0) begin
        regs_d[r] = '0;
      end else if (WR_EN_1 && (WR_ADDR_1 == ADDR_WIDTH'(r))) begin
        regs_d[r] = WR_DATA_1;
      end else if (WR_EN_0 && (WR_ADDR_0 == ADDR_WIDTH'(r))) begin
        regs_d[r] = WR_DATA_0;
      end else begin
        regs_d[r] = regs_q[r];
      end
    end
  end

  // Register storage.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (RST) begin
        regs_q[r] <= '0;
      end else begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign addr_s = RD_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Read mux; address 0 short-circuits ahead of any bypass.
    always_comb begin
      if (addr_s == ZERO_A) begin
        data_s = '0;
      end else if ((BYPASS != 0) && WR_EN_1 && (WR_ADDR_1 == addr_s)) begin
        data_s = WR_DATA_1;
      end else if ((BYPASS != 0) && WR_EN_0 && (WR_ADDR_0 == addr_s)) begin
        data_s = WR_DATA_0;
      end else begin
        data_s = regs_q[addr_s];
      end
    end

    assign RD_DATA[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
  end

  mips_rf_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_RD    (NUM_RD),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (RST),
    .wr_en_0    (WR_EN_0),
    .wr_addr_0  (WR_ADDR_0),
    .wr_en_1    (WR_EN_1),
    .wr_addr_1  (WR_ADDR_1),
    .issue_en   (ISSUE_EN),
    .issue_addr (ISSUE_ADDR),
    .rd_addr    (RD_ADDR),
    .rd_ready   (RD_READY),
    .pending_cnt(PENDING_CNT)
  );

endmodule

// File: tb/tb_mips_reg_file_mp.sv
// Bench for mips_reg_file_mp: directed vector table plus randomized run against a reference model,
// with a bypassing and a non-bypassing instance sharing the same stimulus.
module tb_mips_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we0, we1, iss;
  logic [AW-1:0] wa0, wa1, ia;
  logic [DW-1:0] wd0, wd1;
  logic [NR*AW-1:0] rd_addr;

  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_ready_b, rd_ready_n;
  logic [AW:0]      cnt_b, cnt_n;

  always #5 clk = ~clk;

  mips_reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .CLK(clk), .RST(rst),
    .WR_EN_0(we0), .WR_ADDR_0(wa0), .WR_DATA_0(wd0),
    .WR_EN_1(we1), .WR_ADDR_1(wa1), .WR_DATA_1(wd1),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data_b), .RD_READY(rd_ready_b),
    .ISSUE_EN(iss), .ISSUE_ADDR(ia), .PENDING_CNT(cnt_b)
  );

  mips_reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0)) u_nob (
    .CLK(clk), .RST(rst),
    .WR_EN_0(we0), .WR_ADDR_0(wa0), .WR_DATA_0(wd0),
    .WR_EN_1(we1), .WR_ADDR_1(wa1), .WR_DATA_1(wd1),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data_n), .RD_READY(rd_ready_n),
    .ISSUE_EN(iss), .ISSUE_ADDR(ia), .PENDING_CNT(cnt_n)
  );

  typedef struct {
    string            name;
    logic [NR*DW-1:0] d_b;
    logic [NR*DW-1:0] d_n;
    logic [NR-1:0]    r_b;
    logic [NR-1:0]    r_n;
    logic [AW:0]      cnt;
  } exp_t;

  typedef struct {
    bit rst, we0; logic [AW-1:0] wa0; logic [DW-1:0] wd0;
    bit we1;      logic [AW-1:0] wa1; logic [DW-1:0] wd1;
    bit iss;      logic [AW-1:0] ia;  logic [AW-1:0] ra;
    logic [DW-1:0] ed_b, ed_n;
    bit er_b, er_n;
    logic [AW:0] ecnt;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit [DW-1:0] m_regs [32];
  bit [31:0]   m_pend;

  task automatic check(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model_exp(input string nm);
    exp_t e;
    e.name = nm;
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      bit h0, h1;
      a  = rd_addr[k*AW +: AW];
      h0 = we0 && (wa0 == a);
      h1 = we1 && (wa1 == a);
      if (a == 0) begin
        e.d_b[k*DW +: DW] = '0;
        e.d_n[k*DW +: DW] = '0;
        e.r_b[k] = 1'b1;
        e.r_n[k] = 1'b1;
      end else begin
        e.d_n[k*DW +: DW] = m_regs[a];
        e.d_b[k*DW +: DW] = h1 ? wd1 : (h0 ? wd0 : m_regs[a]);
        e.r_n[k] = !m_pend[a];
        e.r_b[k] = !m_pend[a] || h0 || h1;
      end
    end
    e.cnt = (AW+1)'($countones(m_pend));
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_pend = '0;
    end else begin
      if (we0 && wa0 != 0) m_regs[wa0] = wd0;
      if (we1 && wa1 != 0) m_regs[wa1] = wd1;
      if (we0) m_pend[wa0] = 1'b0;
      if (we1) m_pend[wa1] = 1'b0;
      if (iss) m_pend[ia] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run_cycle(input exp_t e);
    exp_t x;
    q.push_back(e);
    #2;
    x = q.pop_front();
    check({x.name, "/data_byp"}, rd_data_b, x.d_b);
    check({x.name, "/data_nob"}, rd_data_n, x.d_n);
    check({x.name, "/ready_byp"}, NR*DW'(rd_ready_b), NR*DW'(x.r_b));
    check({x.name, "/ready_nob"}, NR*DW'(rd_ready_n), NR*DW'(x.r_n));
    check({x.name, "/cnt_byp"}, NR*DW'(cnt_b), NR*DW'(x.cnt));
    check({x.name, "/cnt_nob"}, NR*DW'(cnt_n), NR*DW'(x.cnt));
    tick();
  endtask

  task automatic add_row(input bit r, input bit e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit is, input logic [AW-1:0] iad, input logic [AW-1:0] ra,
                         input logic [DW-1:0] edb, input logic [DW-1:0] edn,
                         input bit erb, input bit ern, input logic [AW:0] ec);
    vec_t v;
    v.rst = r; v.we0 = e0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.iss = is; v.ia = iad; v.ra = ra;
    v.ed_b = edb; v.ed_n = edn; v.er_b = erb; v.er_n = ern; v.ecnt = ec;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
    wa0 = '0; wa1 = '0; ia = '0; wd0 = '0; wd1 = '0; rd_addr = '0;
    m_pend = '0;
    tick();
    tick();

    //      rst we0 wa0 wd0           we1 wa1 wd1           iss ia  ra   ed_byp        ed_nob        rb rn cnt
    add_row(0, 1, 1, 32'h1111_0001, 1, 2, 32'h2222_0002, 0, 0, 1, 32'h1111_0001, 32'h0,        1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 4, 2, 32'h2222_0002, 32'h2222_0002, 1, 1, 0);
    add_row(1, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFF, 0, 0, 4, 32'h0,        32'h0,        0, 0, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h0,        1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 4, 32'h0,        32'h0,        1, 1, 0);
    add_row(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        1, 1, 0);
    add_row(0, 1, 5, 32'h1111_1111, 1, 5, 32'h2222_2222, 0, 0, 5, 32'h2222_2222, 32'h0,        1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 5, 32'h2222_2222, 32'h2222_2222, 1, 1, 0);
    add_row(0, 0, 0, 32'h0,         1, 7, 32'hA5A5_A5A5, 0, 0, 7, 32'hA5A5_A5A5, 32'h0,        1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 1, 0);
    add_row(0, 1, 7, 32'h5A5A_5A5A, 0, 0, 32'h0,         0, 0, 7, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 3, 32'h0,        32'h0,        1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3, 32'h0,        32'h0,        0, 0, 1);
    add_row(0, 1, 3, 32'h33,        0, 0, 32'h0,         0, 0, 3, 32'h33,       32'h0,        1, 0, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3, 32'h33,       32'h33,       1, 1, 0);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 3, 32'h33,       32'h33,       1, 1, 0);
    add_row(0, 0, 0, 32'h0,         1, 3, 32'h44,        1, 3, 3, 32'h44,       32'h33,       1, 0, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3, 32'h44,       32'h44,       0, 0, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 3, 32'h44,       32'h44,       0, 0, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 3, 32'h44,       32'h44,       0, 0, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 0, 32'h0,        32'h0,        1, 1, 1);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 9, 32'h0,        32'h0,        0, 0, 2);
    add_row(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 9, 32'h0,        32'h0,        0, 0, 2);
    add_row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3, 32'h0,        32'h0,        1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      rst = tbl[i].rst; we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      iss = tbl[i].iss; ia = tbl[i].ia;
      rd_addr = {NR{tbl[i].ra}};
      e.name = $sformatf("vec%0d", i);
      e.d_b = {NR{tbl[i].ed_b}};
      e.d_n = {NR{tbl[i].ed_n}};
      e.r_b = {NR{tbl[i].er_b}};
      e.r_n = {NR{tbl[i].er_n}};
      e.cnt = tbl[i].ecnt;
      run_cycle(e);
    end

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      we0 = $urandom_range(0, 1) != 0;
      we1 = $urandom_range(0, 1) != 0;
      iss = $urandom_range(0, 4) < 2;
      wa0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      wa1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      ia  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      for (int k = 0; k < NR; k++) begin
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, 8));
      end
      run_cycle(model_exp($sformatf("rnd%0d", c)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
